// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, absorbs redirects that arrive
// while fetch is stalled, and parks in HALTED until reset.
module fetch_sequencer #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int          JIMM_W  = 26
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ihit,
   input  logic              stall,
   input  logic              halt,
   input  logic              Branch,
   input  logic              Jump,
   input  logic              JR,
   input  logic [31:0]       bimm,
   input  logic [JIMM_W-1:0] jimm,
   input  logic [31:0]       jraddr,
   output logic [31:0]       pcaddr,
   output logic [31:0]       nxt_pc,
   output logic              imemREN,
   output logic              flush,
   output logic              halted
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      PEND   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [31:0] pend_tgt;
   logic [31:0] pend_n;
   logic [31:0] pc_n;
   logic        flush_n;
   logic [31:0] seq_pc;
   logic [31:0] tgt;
   logic [27:0] jlow;
   logic        redir;
   logic        adv;

   assign seq_pc = pcaddr + 32'd4;
   assign jlow   = 28'({jimm, 2'b00});
   assign redir  = JR | Jump | Branch;
   assign adv    = ihit & ~stall;

   // Redirect target, JR beats Jump beats Branch
   always_comb begin
      tgt = seq_pc + (bimm << 2);
      if (JR)
         tgt = jraddr;
      else if (Jump)
         tgt = {seq_pc[31:28], jlow};
   end

   // State, PC, pending target and flush registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= FETCH;
         pcaddr   <= PC_INIT;
         pend_tgt <= 32'd0;
         flush    <= 1'b0;
      end else begin
         state    <= state_n;
         pcaddr   <= pc_n;
         pend_tgt <= pend_n;
         flush    <= flush_n;
      end
   end

   // Next state: halt wins, then advance, then park a redirect
   always_comb begin
      state_n = state;
      pc_n    = pcaddr;
      pend_n  = pend_tgt;
      flush_n = 1'b0;
      unique case (state)
         FETCH: begin
            if (halt) begin
               state_n = HALTED;
               pend_n  = 32'd0;
            end else begin
               flush_n = redir;
               if (adv)
                  pc_n = redir ? tgt : seq_pc;
               else if (redir) begin
                  pend_n  = tgt;
                  state_n = PEND;
               end
            end
         end
         PEND: begin
            if (halt) begin
               state_n = HALTED;
               pend_n  = 32'd0;
            end else begin
               flush_n = redir;
               if (adv) begin
                  pc_n    = redir ? tgt : pend_tgt;
                  state_n = FETCH;
               end else if (redir)
                  pend_n = tgt;
            end
         end
         HALTED: ;
         default: state_n = FETCH;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      nxt_pc  = seq_pc;
      halted  = (state == HALTED);
      imemREN = (state != HALTED) & ~RST;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run
// compared against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit, stall, halt, Branch, Jump, JR;
   logic [31:0] bimm, jraddr;
   logic [25:0] jimm;
   logic [31:0] pcaddr, nxt_pc;
   logic        imemREN, flush, halted;

   int pass_cnt = 0;
   int total_cnt = 0;

   // behavioural model
   logic [31:0] m_pc;
   bit          m_pv;
   logic [31:0] m_pt;
   bit          m_halted;
   bit          m_flush;

   fetch_sequencer dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .halt(halt),
      .Branch(Branch), .Jump(Jump), .JR(JR), .bimm(bimm), .jimm(jimm),
      .jraddr(jraddr), .pcaddr(pcaddr), .nxt_pc(nxt_pc),
      .imemREN(imemREN), .flush(flush), .halted(halted)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] target();
      logic [31:0] n;
      n = m_pc + 32'd4;
      if (JR) return jraddr;
      if (Jump) return (n & 32'hF000_0000) | ({6'd0, jimm} * 32'd4);
      return n + bimm * 32'd4;
   endfunction

   task automatic model_update();
      bit any, go;
      any = JR || Jump || Branch;
      go  = ihit && !stall;
      if (RST) begin
         m_pc = 32'h0; m_pv = 0; m_pt = 0; m_halted = 0; m_flush = 0;
      end else if (m_halted) begin
         m_flush = 0;
      end else if (halt) begin
         m_halted = 1; m_pv = 0; m_flush = 0;
      end else begin
         m_flush = any;
         if (go) begin
            if (any) m_pc = target();
            else if (m_pv) m_pc = m_pt;
            else m_pc = m_pc + 32'd4;
            m_pv = 0;
         end else if (any) begin
            m_pt = target(); m_pv = 1;
         end
      end
   endtask

   task automatic tick();
      model_update();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      RST = 0; ihit = 0; stall = 0; halt = 0;
      Branch = 0; Jump = 0; JR = 0;
      bimm = 0; jimm = 0; jraddr = 0;
   endtask

   task automatic go_to(input logic [31:0] a);
      idle(); ihit = 1; JR = 1; jraddr = a;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle(); RST = 1; JR = 1; jraddr = 32'h123; halt = 1; ihit = 1;
      tick(); tick();
      total_cnt++;
      if (pcaddr !== 32'h0) $display("FAIL rst_pc got=%h exp=%h", pcaddr, 32'h0);
      else pass_cnt++;
      total_cnt++;
      if (flush !== 1'b0 || halted !== 1'b0)
         $display("FAIL rst_flags got=%b%b exp=00", flush, halted);
      else pass_cnt++;
      total_cnt++;
      if (imemREN !== 1'b0) $display("FAIL rst_ren got=%b exp=0", imemREN);
      else pass_cnt++;
      idle(); #1;
      total_cnt++;
      if (imemREN !== 1'b1) $display("FAIL rst_ren_rel got=%b exp=1", imemREN);
      else pass_cnt++;
   endtask

   task automatic test_sequential();
      logic [31:0] e;
      idle(); ihit = 1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         e = 32'(i * 4);
         total_cnt++;
         if (pcaddr !== e || flush !== 1'b0 || imemREN !== 1'b1)
            $display("FAIL seq%0d pc=%h fl=%b ren=%b exp pc=%h fl=0 ren=1",
                     i, pcaddr, flush, imemREN, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_branch();
      go_to(32'h40);
      ihit = 1; Branch = 1; bimm = 32'hFFFF_FFFC;
      tick();
      total_cnt++;
      if (pcaddr !== 32'h34 || flush !== 1'b1)
         $display("FAIL branch pc=%h fl=%b exp pc=34 fl=1", pcaddr, flush);
      else pass_cnt++;
      idle(); tick();
      total_cnt++;
      if (pcaddr !== 32'h34 || flush !== 1'b0)
         $display("FAIL branch_after pc=%h fl=%b exp pc=34 fl=0", pcaddr, flush);
      else pass_cnt++;
   endtask

   task automatic test_pend_jr();
      go_to(32'h100);
      JR = 1; jraddr = 32'h200;
      tick();
      total_cnt++;
      if (pcaddr !== 32'h100 || flush !== 1'b1)
         $display("FAIL pend_enter pc=%h fl=%b exp pc=100 fl=1", pcaddr, flush);
      else pass_cnt++;
      idle();
      for (int i = 0; i < 2; i++) begin
         tick();
         total_cnt++;
         if (pcaddr !== 32'h100 || flush !== 1'b0)
            $display("FAIL pend_hold%0d pc=%h fl=%b exp pc=100 fl=0", i, pcaddr, flush);
         else pass_cnt++;
      end
      ihit = 1; tick();
      total_cnt++;
      if (pcaddr !== 32'h200 || flush !== 1'b0)
         $display("FAIL pend_load pc=%h fl=%b exp pc=200 fl=0", pcaddr, flush);
      else pass_cnt++;
   endtask

   task automatic test_newer_wins();
      go_to(32'h100);
      JR = 1; jraddr = 32'h300; tick();
      idle(); ihit = 1; Jump = 1; jimm = 26'h80;
      tick();
      total_cnt++;
      if (pcaddr !== 32'h200 || flush !== 1'b1)
         $display("FAIL newer_wins pc=%h fl=%b exp pc=200 fl=1", pcaddr, flush);
      else pass_cnt++;
      idle(); stall = 1; JR = 1; jraddr = 32'h700; tick();
      idle(); ihit = 1; JR = 1; Jump = 1; Branch = 1;
      jraddr = 32'h500; jimm = 26'h10; bimm = 32'h1;
      tick();
      total_cnt++;
      if (pcaddr !== 32'h500) $display("FAIL priority pc=%h exp=500", pcaddr);
      else pass_cnt++;
      idle(); ihit = 1; Jump = 1; Branch = 1; jimm = 26'h10; bimm = 32'h1;
      tick();
      total_cnt++;
      if (pcaddr !== 32'h40) $display("FAIL prio_jb pc=%h exp=40", pcaddr);
      else pass_cnt++;
   endtask

   task automatic test_halt();
      go_to(32'h1C);
      ihit = 1; halt = 1; Branch = 1; bimm = 32'h8;
      tick();
      total_cnt++;
      if (halted !== 1'b1 || imemREN !== 1'b0 || pcaddr !== 32'h1C || flush !== 1'b0)
         $display("FAIL halt_enter h=%b ren=%b pc=%h fl=%b exp 1 0 1c 0",
                  halted, imemREN, pcaddr, flush);
      else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         idle(); ihit = 1; JR = 1; jraddr = $urandom; halt = $urandom_range(0, 1);
         tick();
         total_cnt++;
         if (pcaddr !== 32'h1C || halted !== 1'b1 || flush !== 1'b0)
            $display("FAIL halt_frozen%0d pc=%h h=%b fl=%b exp 1c 1 0",
                     i, pcaddr, halted, flush);
         else pass_cnt++;
      end
      idle(); RST = 1; tick(); idle();
      total_cnt++;
      if (pcaddr !== 32'h0 || halted !== 1'b0)
         $display("FAIL halt_rst pc=%h h=%b exp 0 0", pcaddr, halted);
      else pass_cnt++;
   endtask

   task automatic test_reset_pend();
      go_to(32'h80);
      JR = 1; jraddr = 32'h900; tick();
      idle(); RST = 1; tick();
      idle(); ihit = 1; tick();
      total_cnt++;
      if (pcaddr !== 32'h4 || flush !== 1'b0)
         $display("FAIL rst_pend pc=%h fl=%b exp 4 0", pcaddr, flush);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      go_to(32'hFFFF_FFFC);
      total_cnt++;
      if (nxt_pc !== 32'h0) $display("FAIL wrap_nxt got=%h exp=0", nxt_pc);
      else pass_cnt++;
      ihit = 1; tick();
      total_cnt++;
      if (pcaddr !== 32'h0) $display("FAIL wrap pc=%h exp=0", pcaddr);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 1500; i++) begin
         RST    = ($urandom_range(0, 63) == 0);
         ihit   = $urandom_range(0, 3) != 0;
         stall  = $urandom_range(0, 3) == 0;
         halt   = ($urandom_range(0, 59) == 0);
         Branch = $urandom_range(0, 4) == 0;
         Jump   = $urandom_range(0, 6) == 0;
         JR     = $urandom_range(0, 6) == 0;
         bimm   = $urandom;
         jimm   = 26'($urandom);
         jraddr = $urandom;
         tick();
         total_cnt++;
         if (pcaddr !== m_pc || flush !== m_flush || halted !== m_halted ||
             imemREN !== (!m_halted && !RST) || nxt_pc !== m_pc + 32'd4) begin
            errs++;
            if (errs <= 10)
               $display("FAIL rand%0d pc=%h fl=%b h=%b ren=%b exp pc=%h fl=%b h=%b",
                        i, pcaddr, flush, halted, imemREN, m_pc, m_flush, m_halted);
         end else pass_cnt++;
      end
   endtask

   initial begin
      idle();
      m_pc = 0; m_pv = 0; m_pt = 0; m_halted = 0; m_flush = 0;
      #1;
      test_reset();
      test_sequential();
      test_branch();
      test_pend_jr();
      test_newer_wins();
      test_halt();
      test_reset_pend();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
